execute_cycle_mdu: RTL and testbench
====================================

EXECUTE_CYCLE_MDU -- requirements
Module: execute_cycle_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32 (legal 32 or 64): datapath width.
REQ-002 SHALL have parameter MDU_EN, default 1: 0 = MulDivE ignored, no stall ever raised.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports RD1_E, RD2_E, PCE, PCPlus4E, Imm_Ext_E  input  XLEN  operands, PC, PC+4, extended immediate.
REQ-006 SHALL have ports RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  input  1 each  decoded controls.
REQ-007 SHALL have ports ResultSrcE  input  2, ALUControlE  input  3, RD_E  input  5.
REQ-008 SHALL have ports MulDivE  input  1 (M-extension op), MulDivOpE  input  3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = 0..7).
REQ-009 SHALL have ports ForwardAE, ForwardBE  input  2 (00 register, 01 ResultW, 10 ALUResultM); ResultW  input  XLEN.
REQ-010 SHALL have port FlushE  input  1  kill instruction in E, including any in-flight MDU op.
REQ-011 SHALL have outputs ALUResultM, WriteDataM, PCPlus4M  XLEN; RD_M  5; RegWriteM, MemWriteM  1; ResultSrcM  2 (E/M register).
REQ-012 SHALL have outputs PCTargetE  XLEN (PCE+Imm_Ext_E), PCSrcE  1 ((ZeroE & BranchE) | JumpE), StallE  1 (hold F/D/E).

Function
REQ-013 SHALL select SrcA/forwarded-B via ForwardAE/BE (11 treated as 00), ALU B = Imm_Ext_E when ALUSrcE else forwarded B; ALU ops as existing 3-bit encoding at XLEN width.
REQ-014 SHALL, for non-MDU instructions, load E/M register every cycle with latency 1; WriteDataM = forwarded B (pre-immediate mux).
REQ-015 SHALL implement FSM IDLE, RUN, DONE; reset state IDLE.
REQ-016 SHALL in IDLE with MulDivE=1, FlushE=0, MDU_EN=1: capture forwarded A/B and op into MDU registers, clear counter, assert StallE combinationally that cycle, go RUN.
REQ-017 SHALL in RUN assert StallE, perform one iteration per cycle, go DONE after exactly XLEN RUN cycles (counter wraps at XLEN-1).
REQ-018 SHALL in DONE deassert StallE, load E/M register with MDU result plus the held instruction's RD_E/RegWriteE/ResultSrcE, go IDLE unconditionally (no restart on held MulDivE).
REQ-019 SHALL therefore stall exactly XLEN+1 cycles per MDU op; result visible on ALUResultM XLEN+2 edges after the op first enters E.
REQ-020 SHALL load a bubble (RegWriteM=0, MemWriteM=0, others 0) into E/M on every cycle StallE=1.
REQ-021 SHALL ignore changes on ForwardAE/BE, ResultW, ALUResultM after capture.
REQ-022 SHALL produce RISC-V M results: MUL low XLEN bits; MULH/MULHSU/MULHU high bits with signed x signed/signed x unsigned/unsigned x unsigned.
REQ-023 SHALL on divide by zero return quotient all-ones, remainder = dividend; on signed overflow (most-negative / -1) quotient = dividend, remainder 0; latency unchanged.
REQ-024 SHALL on FlushE=1 in any state: return to IDLE next edge, StallE=0 that cycle, load E/M bubble; flush beats start.
REQ-025 SHALL drive PCSrcE=0 while MulDivE=1.

Reset
REQ-026 SHALL on rst=0 asynchronously clear all E/M outputs to 0, state to IDLE, counter and MDU registers to 0; StallE=0 during reset.
REQ-027 SHALL abandon any in-flight MDU op on reset; no result emitted afterwards.

Structure
REQ-028 SHALL take ALUControl encodings, MulDivOp encodings, Forward select codes and FSM state enum from shared package exe_pkg.
REQ-029 SHALL place iterative multiply/divide datapath (shift-add multiplier, restoring divider, sign fix-up) in sub-module mdu_iter; FSM, forwarding, E/M register stay top-level.

Verification (XLEN=32)
REQ-030 SHALL check MUL 7 x 0xFFFFFFFD -> StallE high 33 cycles, ALUResultM=0xFFFFFFEB, RegWriteM=1 once.
REQ-031 SHALL check MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-032 SHALL check DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM same operands -> 0; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
REQ-033 SHALL check forwarded operand (ForwardAE=10, ALUResultM=12) with ALUResultM changing mid-RUN -> DIVU 12/4 = 3.
REQ-034 SHALL check FlushE asserted at RUN cycle 10 -> next cycle IDLE, StallE=0, RegWriteM=0; following ADD completes latency 1.
REQ-035 SHALL check rst=0 mid-RUN -> all outputs 0 immediately, no later result write.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU controls, M-extension ops,
// forwarding selects and the MDU sequencing states.
package exe_pkg;

   typedef enum logic [2:0] {
      AluAdd = 3'b000,
      AluSub = 3'b001,
      AluAnd = 3'b010,
      AluOr  = 3'b011,
      AluXor = 3'b100,
      AluSlt = 3'b101,
      AluSll = 3'b110,
      AluSrl = 3'b111
   } aluCtrl_e;

   typedef enum logic [2:0] {
      OpMul    = 3'd0,
      OpMulh   = 3'd1,
      OpMulhsu = 3'd2,
      OpMulhu  = 3'd3,
      OpDiv    = 3'd4,
      OpDivu   = 3'd5,
      OpRem    = 3'd6,
      OpRemu   = 3'd7
   } mdOp_e;

   localparam logic [1:0] FwdReg     = 2'b00;
   localparam logic [1:0] FwdResultW = 2'b01;
   localparam logic [1:0] FwdAluM    = 2'b10;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } exeState_e;

endpackage

// File: rtl/mdu_iter.sv
// Shift-add multiplier and restoring divider sharing one {hi, lo} register;
// operates on magnitudes, one bit per step, signs restored on the output.
module mdu_iter
   import exe_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   input  logic [2:0]      op,
   output logic [XLEN-1:0] result
);

   mdOp_e             opReg;
   logic              divMode;
   logic              negRes;
   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;
   logic [XLEN-1:0]   mcand;
   logic              signA;
   logic              signB;
   logic [XLEN-1:0]   absA;
   logic [XLEN-1:0]   absB;
   logic [XLEN:0]     mulSum;
   logic [XLEN:0]     divShift;
   logic              divFits;
   logic [2*XLEN-1:0] prodFix;
   logic [XLEN-1:0]   quotFix;
   logic [XLEN-1:0]   remFix;

   always_comb begin
      signA = 1'b0;
      signB = 1'b0;
      unique case (mdOp_e'(op))
         OpMulh, OpDiv, OpRem: begin
            signA = opA[XLEN-1];
            signB = opB[XLEN-1];
         end
         OpMulhsu: signA = opA[XLEN-1];
         default: ;
      endcase
   end

   assign absA     = signA ? -opA : opA;
   assign absB     = signB ? -opB : opB;
   assign mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
   assign divShift = {hi, lo[XLEN-1]};
   assign divFits  = divShift >= {1'b0, mcand};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opReg   <= OpMul;
         divMode <= 1'b0;
         negRes  <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         mcand   <= '0;
      end else if (start) begin
         opReg   <= mdOp_e'(op);
         divMode <= op[2];
         hi      <= '0;
         if (op[2]) begin
            lo    <= absA;
            mcand <= absB;
            // Divide-by-zero quotient must stay all-ones, so never negate it.
            negRes <= op[1] ? signA : ((signA ^ signB) && (opB != '0));
         end else begin
            lo     <= absB;
            mcand  <= absA;
            negRes <= signA ^ signB;
         end
      end else if (step) begin
         if (divMode) begin
            hi <= divFits ? divShift[XLEN-1:0] - mcand : divShift[XLEN-1:0];
            lo <= {lo[XLEN-2:0], divFits};
         end else begin
            {hi, lo} <= {mulSum, lo[XLEN-1:1]};
         end
      end
   end

   assign prodFix = negRes ? -{hi, lo} : {hi, lo};
   assign quotFix = negRes ? -lo : lo;
   assign remFix  = negRes ? -hi : hi;

   always_comb begin
      unique case (opReg)
         OpMul:                     result = prodFix[XLEN-1:0];
         OpMulh, OpMulhsu, OpMulhu: result = prodFix[2*XLEN-1:XLEN];
         OpDiv, OpDivu:             result = quotFix;
         default:                   result = remFix;
      endcase
   end

endmodule

// File: rtl/execute_cycle_mdu.sv
// Execute stage: forwarding, ALU, branch target, E/M register and the
// sequencer that holds the front of the pipe while an M-extension op iterates.
module execute_cycle_mdu
   import exe_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter bit          MDU_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [XLEN-1:0] Imm_Ext_E,
   input  logic            RegWriteE,
   input  logic            ALUSrcE,
   input  logic            MemWriteE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic [1:0]      ResultSrcE,
   input  logic [2:0]      ALUControlE,
   input  logic [4:0]      RD_E,
   input  logic            MulDivE,
   input  logic [2:0]      MulDivOpE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [4:0]      RD_M,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultSrcM,
   output logic [XLEN-1:0] PCTargetE,
   output logic            PCSrcE,
   output logic            StallE
);

   localparam int unsigned CntW = $clog2(XLEN);

   exeState_e       state;
   logic [CntW-1:0] cnt;
   logic [XLEN-1:0] fwdA;
   logic [XLEN-1:0] fwdB;
   logic [XLEN-1:0] srcB;
   logic [XLEN-1:0] aluRes;
   logic [XLEN-1:0] mduResult;
   logic            mduStart;
   logic            mduStep;

   always_comb begin
      case (ForwardAE)
         FwdResultW: fwdA = ResultW;
         FwdAluM:    fwdA = ALUResultM;
         default:    fwdA = RD1_E;
      endcase
      case (ForwardBE)
         FwdResultW: fwdB = ResultW;
         FwdAluM:    fwdB = ALUResultM;
         default:    fwdB = RD2_E;
      endcase
   end

   assign srcB = ALUSrcE ? Imm_Ext_E : fwdB;

   always_comb begin
      unique case (aluCtrl_e'(ALUControlE))
         AluAdd: aluRes = fwdA + srcB;
         AluSub: aluRes = fwdA - srcB;
         AluAnd: aluRes = fwdA & srcB;
         AluOr:  aluRes = fwdA | srcB;
         AluXor: aluRes = fwdA ^ srcB;
         AluSlt: aluRes = {{(XLEN-1){1'b0}}, $signed(fwdA) < $signed(srcB)};
         AluSll: aluRes = fwdA << srcB[CntW-1:0];
         AluSrl: aluRes = fwdA >> srcB[CntW-1:0];
      endcase
   end

   assign PCTargetE = PCE + Imm_Ext_E;
   assign PCSrcE    = !MulDivE && (((aluRes == '0) && BranchE) || JumpE);

   // Stall starts in the capture cycle itself so the op is held in E from its first cycle.
   assign mduStart = MDU_EN && rst && MulDivE && !FlushE && (state == StIdle);
   assign mduStep  = !FlushE && (state == StRun);
   assign StallE   = mduStart || mduStep;

   mdu_iter #(
      .XLEN(XLEN)
   ) uMdu (
      .clk   (clk),
      .rst   (rst),
      .start (mduStart),
      .step  (mduStep),
      .opA   (fwdA),
      .opB   (fwdB),
      .op    (MulDivOpE),
      .result(mduResult)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= StIdle;
         cnt        <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
         RD_M       <= '0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= '0;
      end else begin
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
         RD_M       <= '0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= '0;
         if (FlushE) begin
            state <= StIdle;
         end else begin
            unique case (state)
               StIdle: begin
                  if (mduStart) begin
                     state <= StRun;
                     cnt   <= '0;
                  end else begin
                     ALUResultM <= aluRes;
                     WriteDataM <= fwdB;
                     PCPlus4M   <= PCPlus4E;
                     RD_M       <= RD_E;
                     RegWriteM  <= RegWriteE;
                     MemWriteM  <= MemWriteE;
                     ResultSrcM <= ResultSrcE;
                  end
               end
               StRun: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CntW'(XLEN - 1)) state <= StDone;
               end
               StDone: begin
                  state      <= StIdle;
                  ALUResultM <= mduResult;
                  PCPlus4M   <= PCPlus4E;
                  RD_M       <= RD_E;
                  RegWriteM  <= RegWriteE;
                  ResultSrcM <= ResultSrcE;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_execute_cycle_mdu.sv
// Directed and randomized checks of execute_cycle_mdu against a plain-arithmetic
// reference for ALU results and RISC-V M-extension results.
module tb_execute_cycle_mdu;

   logic        clk;
   logic        rst;
   logic [31:0] RD1_E, RD2_E, PCE, PCPlus4E, Imm_Ext_E, ResultW;
   logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, MulDivE, FlushE;
   logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
   logic [2:0]  ALUControlE, MulDivOpE;
   logic [4:0]  RD_E;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
   logic [4:0]  RD_M;
   logic        RegWriteM, MemWriteM, PCSrcE, StallE;
   logic [1:0]  ResultSrcM;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] expAluM = '0;

   execute_cycle_mdu #(
      .XLEN  (32),
      .MDU_EN(1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .RD1_E      (RD1_E),
      .RD2_E      (RD2_E),
      .PCE        (PCE),
      .PCPlus4E   (PCPlus4E),
      .Imm_Ext_E  (Imm_Ext_E),
      .RegWriteE  (RegWriteE),
      .ALUSrcE    (ALUSrcE),
      .MemWriteE  (MemWriteE),
      .BranchE    (BranchE),
      .JumpE      (JumpE),
      .ResultSrcE (ResultSrcE),
      .ALUControlE(ALUControlE),
      .RD_E       (RD_E),
      .MulDivE    (MulDivE),
      .MulDivOpE  (MulDivOpE),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .ResultW    (ResultW),
      .FlushE     (FlushE),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RD_M       (RD_M),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .PCTargetE  (PCTargetE),
      .PCSrcE     (PCSrcE),
      .StallE     (StallE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] refAlu(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
      case (c)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6:    return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   function automatic logic [31:0] refMdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic setNop();
      MulDivE = 1'b0; FlushE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
      RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; ALUSrcE = 1'b0; ALUControlE = 3'd0;
      ForwardAE = 2'b00; ForwardBE = 2'b00; BranchE = 1'b0; JumpE = 1'b0;
      RD_E = '0; ResultSrcE = '0; MulDivOpE = '0; ResultW = '0; PCE = '0; PCPlus4E = '0;
   endtask

   task automatic aluStep(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [31:0] rw, input string tag);
      logic [31:0] fA, fB, res, pc;
      logic        jp;
      logic [4:0]  rd;
      logic [1:0]  rs;
      fA  = (fa == 2'b01) ? rw : (fa == 2'b10) ? expAluM : a;
      fB  = (fb == 2'b01) ? rw : (fb == 2'b10) ? expAluM : b;
      res = refAlu(c, fA, src ? imm : fB);
      jp  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom);
      rs  = 2'($urandom);
      pc  = $urandom;
      MulDivE = 1'b0; FlushE = 1'b0; ALUControlE = c; RD1_E = a; RD2_E = b;
      Imm_Ext_E = imm; ALUSrcE = src; ForwardAE = fa; ForwardBE = fb; ResultW = rw;
      BranchE = 1'b1; JumpE = jp; RegWriteE = 1'b1; MemWriteE = src; RD_E = rd;
      ResultSrcE = rs; PCE = pc; PCPlus4E = pc + 32'd4;
      #1;
      check({tag, " target"}, PCTargetE, pc + imm);
      check({tag, " pcsrc"}, 32'(PCSrcE), 32'((res == 0) || jp));
      check({tag, " stall"}, 32'(StallE), 32'd0);
      tick();
      check({tag, " result"}, ALUResultM, res);
      check({tag, " wdata"}, WriteDataM, fB);
      check({tag, " ctl"}, {20'd0, PCPlus4M[3:0], RD_M, RegWriteM, MemWriteM, ResultSrcM},
            {20'd0, pc[3:0] + 4'd4, rd, 1'b1, src, rs});
      expAluM = res;
   endtask

   task automatic runMdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [31:0] exp, input string tag);
      int   n;
      logic early;
      setNop();
      MulDivE = 1'b1; MulDivOpE = op; RD1_E = a; RD2_E = b; ForwardAE = fa;
      RegWriteE = 1'b1; RD_E = 5'd9; JumpE = 1'b1;
      #1;
      check({tag, " pcsrc"}, 32'(PCSrcE), 32'd0);
      n     = 0;
      early = 1'b0;
      while (StallE === 1'b1 && n < 100) begin
         n++;
         tick();
         if (RegWriteM !== 1'b0) early = 1'b1;
         ForwardAE = 2'($urandom);
         ForwardBE = 2'($urandom);
         ResultW   = $urandom;
      end
      check({tag, " stall cycles"}, 32'(n), 32'd33);
      check({tag, " bubble"}, 32'(early), 32'd0);
      tick();
      check({tag, " result"}, ALUResultM, exp);
      check({tag, " write"}, {26'd0, RD_M, RegWriteM}, {26'd0, 5'd9, 1'b1});
      setNop();
      tick();
      check({tag, " once"}, {31'd0, RegWriteM}, 32'd0);
      expAluM = '0;
   endtask

   task automatic quietCycles(input int n, input string tag);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         tick();
         if (StallE !== 1'b0 || RegWriteM !== 1'b0 || ALUResultM !== '0) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      setNop();
      rst     = 1'b0;
      MulDivE = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset stall", 32'(StallE), 32'd0);
      check("reset em", {ALUResultM[15:0], RD_M, RegWriteM, MemWriteM, ResultSrcM, 7'd0},
            32'd0);
      setNop();
      rst = 1'b1;
      tick();

      // Directed M-extension cases with hand-computed results
      runMdu(3'd0, 32'd7, 32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFEB, "mul");
      runMdu(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, "mulhu");
      runMdu(3'd1, 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h4000_0000, "mulh");
      runMdu(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, "div ovf");
      runMdu(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, "rem ovf");
      runMdu(3'd5, 32'd5, 32'd0, 2'b00, 32'hFFFF_FFFF, "divu zero");
      runMdu(3'd7, 32'd5, 32'd0, 2'b00, 32'd5, "remu zero");

      // Forwarded dividend from ALUResultM, which goes to a bubble during RUN
      aluStep(3'd0, 32'd5, 32'd0, 32'd7, 1'b1, 2'b00, 2'b00, 32'd0, "add12");
      runMdu(3'd5, 32'd99, 32'd4, 2'b10, 32'd3, "divu fwd");

      for (int i = 0; i < 10; i++) begin
         aluStep(3'($urandom), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 2'($urandom), 2'($urandom), $urandom, "alu rnd");
      end
      aluStep(3'd1, 32'h1234, 32'h1234, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, "sub zero");

      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom);
         a  = pick();
         b  = pick();
         runMdu(op, a, b, 2'b00, refMdu(op, a, b), "mdu rnd");
      end

      // Flush at RUN cycle 10, then an ADD must complete with latency 1
      setNop();
      MulDivE = 1'b1; MulDivOpE = 3'd4; RD1_E = 32'd100; RD2_E = 32'd7; RegWriteE = 1'b1;
      #1;
      check("flush start stall", 32'(StallE), 32'd1);
      repeat (10) tick();
      FlushE = 1'b1;
      #1;
      check("flush stall", 32'(StallE), 32'd0);
      tick();
      check("flush bubble", {31'd0, RegWriteM}, 32'd0);
      setNop();
      RD1_E = 32'd20; Imm_Ext_E = 32'd22; ALUSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd3;
      #1;
      check("flush idle", 32'(StallE), 32'd0);
      tick();
      check("flush add", ALUResultM, 32'd42);
      check("flush add we", {26'd0, RD_M, RegWriteM}, {26'd0, 5'd3, 1'b1});
      setNop();
      quietCycles(40, "flush quiet");

      // Asynchronous reset clears a loaded E/M register between edges
      aluStep(3'd3, 32'h00F0_0000, 32'h0000_000F, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, "or");
      #2;
      rst = 1'b0;
      #1;
      check("async rst result", ALUResultM, 32'd0);
      check("async rst we", {31'd0, RegWriteM}, 32'd0);
      tick();
      rst = 1'b1;
      expAluM = '0;

      // Reset mid-RUN abandons the op
      setNop();
      MulDivE = 1'b1; MulDivOpE = 3'd5; RD1_E = 32'd1000; RD2_E = 32'd3; RegWriteE = 1'b1;
      repeat (6) tick();
      rst = 1'b0;
      #1;
      check("rst run stall", 32'(StallE), 32'd0);
      check("rst run em", {ALUResultM[24:0], RD_M, RegWriteM, MemWriteM}, 32'd0);
      tick();
      setNop();
      rst = 1'b1;
      quietCycles(40, "rst quiet");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
